// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 execute stage: ALU opcode encodings and default widths.
package legv8_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int PC_INCR_DEF    = 4;

    localparam logic [2:0] ALU_AND    = 3'b000;
    localparam logic [2:0] ALU_ORR    = 3'b001;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_EOR    = 3'b011;
    localparam logic [2:0] ALU_LSL    = 3'b100;
    localparam logic [2:0] ALU_LSR    = 3'b101;
    localparam logic [2:0] ALU_SUB    = 3'b110;
    localparam logic [2:0] ALU_PASS_B = 3'b111;

endpackage

// File: rtl/legv8_alu_core.sv
// Combinational LEGv8 ALU: opcode mux over A/B plus zero detect on the selected result.
module legv8_alu_core
    import legv8_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [2:0]            op_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic [SHAMT_W-1:0] shamt;

    // Only the low bits of B steer the shifter, so an out-of-range shift cannot occur.
    assign shamt = b_i[SHAMT_W-1:0];

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        result_o = '0;
        case (op_i)
            ALU_AND:    result_o = a_i & b_i;
            ALU_ORR:    result_o = a_i | b_i;
            ALU_ADD:    result_o = a_i + b_i;
            ALU_EOR:    result_o = a_i ^ b_i;
            ALU_LSL:    result_o = a_i << shamt;
            ALU_LSR:    result_o = a_i >> shamt;
            ALU_SUB:    result_o = a_i - b_i;
            ALU_PASS_B: result_o = b_i;
            default:    result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/legv8_exec_adders.sv
// LEGv8 execute stage: ALU plus sequential and branch PC adders, all results registered on clk.
module legv8_exec_adders
    import legv8_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int PC_INCR    = PC_INCR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [2:0]            alu_operation,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [ADDR_WIDTH-1:0] branch_offset,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic [ADDR_WIDTH-1:0] pc_next_seq,
    output logic [ADDR_WIDTH-1:0] branch_target
);

    logic [DATA_WIDTH-1:0] result_d, result_q;
    logic                  zero_d,   zero_q;
    logic [ADDR_WIDTH-1:0] pc_seq_d, pc_seq_q;
    logic [ADDR_WIDTH-1:0] br_tgt_d, br_tgt_q;

    legv8_alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_core (
        .a_i      (a_in),
        .b_i      (b_in),
        .op_i     (alu_operation),
        .result_o (result_d),
        .zero_o   (zero_d)
    );

    // Unsigned adders wrap modulo 2^ADDR_WIDTH; a two's-complement offset yields a backward branch.
    assign pc_seq_d = pc_in + ADDR_WIDTH'(PC_INCR);
    assign br_tgt_d = pc_in + branch_offset;

    // Zero clears to 0 during reset so the branch AND gate never fires spuriously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            pc_seq_q <= '0;
            br_tgt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            result_q <= result_d;
            zero_q   <= zero_d;
            pc_seq_q <= pc_seq_d;
            br_tgt_q <= br_tgt_d;
        end
    end

    assign result        = result_q;
    assign zero          = zero_q;
    assign pc_next_seq   = pc_seq_q;
    assign branch_target = br_tgt_q;

endmodule

// File: tb/tb_legv8_exec_adders.sv
// Directed bench for legv8_exec_adders: vector table plus async-reset sequences.
module tb_legv8_exec_adders;

    logic        clk;
    logic        reset;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [2:0]  alu_operation;
    logic [31:0] pc_in;
    logic [31:0] branch_offset;
    logic [63:0] result;
    logic        zero;
    logic [31:0] pc_next_seq;
    logic [31:0] branch_target;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  op;
        logic [31:0] pc;
        logic [31:0] off;
        logic [63:0] exp_result;
        logic        exp_zero;
        logic [31:0] exp_seq;
        logic [31:0] exp_bt;
    } vec_t;

    vec_t vecs[14];

    legv8_exec_adders dut (
        .clk           (clk),
        .reset         (reset),
        .a_in          (a_in),
        .b_in          (b_in),
        .alu_operation (alu_operation),
        .pc_in         (pc_in),
        .branch_offset (branch_offset),
        .result        (result),
        .zero          (zero),
        .pc_next_seq   (pc_next_seq),
        .branch_target (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_all(input string name, input logic [63:0] r, input logic z,
                             input logic [31:0] s, input logic [31:0] t);
        check({name, ".result"}, result, r);
        check({name, ".zero"}, {63'd0, zero}, {63'd0, z});
        check({name, ".pc_next_seq"}, {32'd0, pc_next_seq}, {32'd0, s});
        check({name, ".branch_target"}, {32'd0, branch_target}, {32'd0, t});
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                         input logic [31:0] pc, input logic [31:0] off);
        a_in = a; b_in = b; alu_operation = op; pc_in = pc; branch_offset = off;
    endtask

    initial begin
        vecs[0]  = '{"add",      64'd5,      64'd7,      3'b010, 32'd100,        32'hFFFF_FFF8, 64'd12,                  1'b0, 32'd104, 32'd92};
        vecs[1]  = '{"sub_eq",   64'd9,      64'd9,      3'b110, 32'hFFFF_FFFC,  32'd8,         64'd0,                   1'b1, 32'd0,   32'd4};
        vecs[2]  = '{"and",      64'hF0F0,   64'h0FF0,   3'b000, 32'd0,          32'd0,         64'h00F0,                1'b0, 32'd4,   32'd0};
        vecs[3]  = '{"orr",      64'hF0F0,   64'h0FF0,   3'b001, 32'h1000,       32'h20,        64'hFFF0,                1'b0, 32'h1004, 32'h1020};
        vecs[4]  = '{"eor",      64'hF0F0,   64'h0FF0,   3'b011, 32'd8,          32'hFFFF_FFF8, 64'hFF00,                1'b0, 32'd12,  32'd0};
        vecs[5]  = '{"pass_b",   64'hF0F0,   64'h0FF0,   3'b111, 32'd200,        32'd40,        64'h0FF0,                1'b0, 32'd204, 32'd240};
        vecs[6]  = '{"add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 32'd16, 32'd16,        64'd0,                   1'b1, 32'd20,  32'd32};
        vecs[7]  = '{"sub_brw",  64'd0,      64'd1,      3'b110, 32'd24,         32'd4,         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'd28,  32'd28};
        vecs[8]  = '{"lsl63",    64'd1,      64'd63,     3'b100, 32'd32,         32'd0,         64'h8000_0000_0000_0000, 1'b0, 32'd36,  32'd32};
        vecs[9]  = '{"lsr63",    64'h8000_0000_0000_0000, 64'd63, 3'b101, 32'd36, 32'd4,        64'd1,                   1'b0, 32'd40,  32'd40};
        vecs[10] = '{"lsl64",    64'h1234,   64'd64,     3'b100, 32'd40,         32'd0,         64'h1234,                1'b0, 32'd44,  32'd40};
        vecs[11] = '{"lsr64",    64'hABCD,   64'd64,     3'b101, 32'd44,         32'd0,         64'hABCD,                1'b0, 32'd48,  32'd44};
        vecs[12] = '{"lsl4",     64'h0F,     64'd4,      3'b100, 32'd48,         32'd0,         64'hF0,                  1'b0, 32'd52,  32'd48};
        vecs[13] = '{"pass_b0",  64'hDEAD,   64'd0,      3'b111, 32'd52,         32'd0,         64'd0,                   1'b1, 32'd56,  32'd52};

        // Asynchronous clear before any clock edge, with non-zero inputs.
        drive(64'd5, 64'd7, 3'b010, 32'd100, 32'd8);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #2;
        check_all("reset_async", 64'd0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check_all("reset_held", 64'd0, 1'b0, 32'd0, 32'd0);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].pc, vecs[i].off);
            @(posedge clk); #1;
            check_all(vecs[i].name, vecs[i].exp_result, vecs[i].exp_zero, vecs[i].exp_seq, vecs[i].exp_bt);
            @(negedge clk);
        end

        // Mid-sequence reset: in-flight sample discarded, outputs clear at once.
        drive(64'd5, 64'd7, 3'b010, 32'd100, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        check_all("pre_reset", 64'd12, 1'b0, 32'd104, 32'd92);
        @(negedge clk);
        drive(64'd3, 64'd4, 3'b010, 32'd8, 32'd8);
        reset = 1'b0;
        #1;
        check_all("mid_reset", 64'd0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check_all("mid_reset_edge", 64'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("post_release", 64'd0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check_all("resume", 64'd7, 1'b0, 32'd12, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
